// File: rtl/sd_cmd_controller.sv
// SD card SPI-mode command engine: frames a command with CRC7 into the TX FIFO,
// drains the echo bytes, then polls with 0xFF until an R1 byte or a timeout.
module sd_cmd_controller #(
  parameter int unsigned PACKAGE_WIDTH = 8,
  parameter int unsigned RESP_TIMEOUT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [5:0]               cmd_index,
  input  logic [31:0]              cmd_arg,
  output logic                     resp_valid,
  output logic [7:0]               resp_r1,
  output logic                     resp_timeout,
  output logic                     busy,
  output logic                     tx_fifo_wr_en,
  output logic [PACKAGE_WIDTH-1:0] tx_fifo_wr_data,
  input  logic                     tx_fifo_wr_full,
  output logic                     rx_fifo_rd_en,
  input  logic [PACKAGE_WIDTH-1:0] rx_fifo_rd_data,
  input  logic                     rx_fifo_rd_empty
);

  localparam int unsigned CNT_W       = 3;
  localparam int unsigned POLL_W      = 8;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(6);

  typedef enum logic [2:0] {
    IDLE,
    XFER,
    POLL_TX,
    POLL_RX,
    POLL_CHK,
    DONE
  } state_t;

  state_t              state;
  logic [5:0]          idx_q;
  logic [31:0]         arg_q;
  logic [CNT_W-1:0]    wr_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic [POLL_W-1:0]   poll_cnt;
  logic [6:0]          crc;
  logic [7:0]          frame_byte;
  logic [7:0]          rx_byte;

  // Bitwise CRC7 (x^7 + x^3 + 1), MSB first, seed 0.
  function automatic logic [6:0] crc7(input logic [39:0] msg);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = msg[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Frame byte selected by the write counter.
  always_comb begin
    crc        = crc7({2'b01, idx_q, arg_q});
    frame_byte = 8'hFF;
    case (wr_cnt)
      3'd0:    frame_byte = {2'b01, idx_q};
      3'd1:    frame_byte = arg_q[31:24];
      3'd2:    frame_byte = arg_q[23:16];
      3'd3:    frame_byte = arg_q[15:8];
      3'd4:    frame_byte = arg_q[7:0];
      3'd5:    frame_byte = {crc, 1'b1};
      default: frame_byte = 8'hFF;
    endcase
    rx_byte = rx_fifo_rd_data[7:0];
  end

  // Strobes are registered and never issued back-to-back, so the full/empty
  // flag sampled in an idle cycle is still valid when the strobe is driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cmd_ready       <= 1'b0;
      busy            <= 1'b0;
      resp_valid      <= 1'b0;
      resp_r1         <= 8'h00;
      resp_timeout    <= 1'b0;
      tx_fifo_wr_en   <= 1'b0;
      tx_fifo_wr_data <= '0;
      rx_fifo_rd_en   <= 1'b0;
      idx_q           <= 6'd0;
      arg_q           <= 32'd0;
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      poll_cnt        <= '0;
    end else begin
      tx_fifo_wr_en <= 1'b0;
      rx_fifo_rd_en <= 1'b0;
      resp_valid    <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            idx_q     <= cmd_index;
            arg_q     <= cmd_arg;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            poll_cnt  <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (wr_cnt != FRAME_LEN && !tx_fifo_wr_full && !tx_fifo_wr_en) begin
            tx_fifo_wr_en   <= 1'b1;
            tx_fifo_wr_data <= PACKAGE_WIDTH'(frame_byte);
            wr_cnt          <= wr_cnt + CNT_W'(1);
          end
          if (rd_cnt != FRAME_LEN && !rx_fifo_rd_empty && !rx_fifo_rd_en) begin
            rx_fifo_rd_en <= 1'b1;
            rd_cnt        <= rd_cnt + CNT_W'(1);
          end
          if (wr_cnt == FRAME_LEN && rd_cnt == FRAME_LEN && !tx_fifo_wr_en && !rx_fifo_rd_en)
            state <= POLL_TX;
        end
        POLL_TX: begin
          if (!tx_fifo_wr_full && !tx_fifo_wr_en) begin
            tx_fifo_wr_en   <= 1'b1;
            tx_fifo_wr_data <= PACKAGE_WIDTH'(8'hFF);
            poll_cnt        <= poll_cnt + POLL_W'(1);
            state           <= POLL_RX;
          end
        end
        POLL_RX: begin
          if (!rx_fifo_rd_empty && !rx_fifo_rd_en) begin
            rx_fifo_rd_en <= 1'b1;
            state         <= POLL_CHK;
          end
        end
        POLL_CHK: begin
          // First cycle is the read strobe itself; data is valid the cycle after.
          if (!rx_fifo_rd_en) begin
            if (!rx_byte[7]) begin
              resp_r1      <= rx_byte;
              resp_timeout <= 1'b0;
              resp_valid   <= 1'b1;
              state        <= DONE;
            end else if (poll_cnt >= POLL_W'(RESP_TIMEOUT)) begin
              resp_r1      <= 8'hFF;
              resp_timeout <= 1'b1;
              resp_valid   <= 1'b1;
              state        <= DONE;
            end else begin
              state <= POLL_TX;
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Bench for sd_cmd_controller: FIFO/card model with loopback echo and scripted
// poll replies; expected frames and responses come from a reference model.
module tb_sd_cmd_controller;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_valid;
  logic [7:0]  resp_r1;
  logic        resp_timeout;
  logic        busy;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_wr_data;
  logic        tx_fifo_wr_full  = 1'b0;
  logic        rx_fifo_rd_en;
  logic [7:0]  rx_fifo_rd_data  = 8'h00;
  logic        rx_fifo_rd_empty = 1'b1;

  int errors = 0;
  int checks = 0;

  // Monitor-owned state
  logic [7:0] rxq[$];
  logic [7:0] txall[$];
  int wtotal     = 0;
  int stall_left = 0;
  int rv_count   = 0;
  int viol_w     = 0;
  int viol_r     = 0;

  // Main-owned state
  logic [7:0] script[$];
  int wbase   = 0;
  int stall_at = -1;

  always #5 clk = ~clk;

  sd_cmd_controller #(.PACKAGE_WIDTH(8), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_timeout(resp_timeout),
    .busy(busy),
    .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_wr_data(tx_fifo_wr_data),
    .tx_fifo_wr_full(tx_fifo_wr_full),
    .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_rd_data(rx_fifo_rd_data),
    .rx_fifo_rd_empty(rx_fifo_rd_empty)
  );

  // FIFO + card model: frame bytes echo back, poll bytes return the script.
  always @(posedge clk) begin
    logic       w, r, f, e;
    logic [7:0] wd;
    int         p;
    w  = tx_fifo_wr_en;
    wd = tx_fifo_wr_data;
    r  = rx_fifo_rd_en;
    f  = tx_fifo_wr_full;
    e  = rx_fifo_rd_empty;
    if (resp_valid) rv_count++;
    #1;
    if (rst) begin
      rxq.delete();
      stall_left       = 0;
      tx_fifo_wr_full  = 1'b0;
      rx_fifo_rd_empty = 1'b1;
    end else begin
      if (w) begin
        if (f) viol_w++;
        txall.push_back(wd);
        p = wtotal - wbase - 6;
        if (p < 0) rxq.push_back(wd);
        else if (p < script.size()) rxq.push_back(script[p]);
        else rxq.push_back(8'hFF);
        if (wtotal - wbase == stall_at) stall_left = 20;
        wtotal++;
      end
      if (r) begin
        if (e) viol_r++;
        if (rxq.size() > 0) rx_fifo_rd_data = rxq.pop_front();
      end
      if (stall_left > 0) begin
        tx_fifo_wr_full = 1'b1;
        stall_left--;
      end else begin
        tx_fifo_wr_full = 1'b0;
      end
      rx_fifo_rd_empty = (rxq.size() == 0);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 as polynomial long division of M(x)*x^7 by 0x89.
  function automatic logic [6:0] ref_crc(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic check_reset_vals(input string p);
    check({p, "_cmd_ready"}, cmd_ready, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_resp_valid"}, resp_valid, 0);
    check({p, "_resp_r1"}, resp_r1, 0);
    check({p, "_resp_timeout"}, resp_timeout, 0);
    check({p, "_wr_en"}, tx_fifo_wr_en, 0);
    check({p, "_wr_data"}, tx_fifo_wr_data, 0);
    check({p, "_rd_en"}, rx_fifo_rd_en, 0);
  endtask

  task automatic issue_cmd(input logic [5:0] idx, input logic [31:0] arg, input int stall);
    int cyc;
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_cmd", cmd_ready, 1);
    wbase     = wtotal;
    stall_at  = stall;
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_low_when_busy", cmd_ready, 0);
  endtask

  // Runs one command (script already loaded) and checks frame, polls and response.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int stall,
                         input bit poke);
    logic [7:0] exp[$];
    logic [6:0] c;
    logic [7:0] er1;
    logic       eto;
    int         npoll, cyc, rv0, vw0, vr0;
    c = ref_crc({2'b01, idx, arg});
    exp.push_back({2'b01, idx});
    exp.push_back(arg[31:24]);
    exp.push_back(arg[23:16]);
    exp.push_back(arg[15:8]);
    exp.push_back(arg[7:0]);
    exp.push_back({c, 1'b1});
    npoll = TO; er1 = 8'hFF; eto = 1'b1;
    for (int k = 0; k < TO; k++) begin
      if (k < script.size() && script[k][7] == 1'b0) begin
        npoll = k + 1; er1 = script[k]; eto = 1'b0;
        break;
      end
    end
    for (int k = 0; k < npoll; k++) exp.push_back(8'hFF);

    rv0 = rv_count; vw0 = viol_w; vr0 = viol_r;
    issue_cmd(idx, arg, stall);
    if (poke) begin
      repeat (3) @(negedge clk);
      cmd_index = ~idx;
      cmd_arg   = ~arg;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    cyc = 0;
    while (!resp_valid && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("resp_valid_seen", resp_valid, 1);
    check("resp_r1", resp_r1, er1);
    check("resp_timeout", resp_timeout, eto);
    check("tx_byte_count", txall.size() - wbase, exp.size());
    for (int k = 0; k < exp.size(); k++)
      if (wbase + k < txall.size())
        check($sformatf("tx_byte%0d", k), txall[wbase + k], exp[k]);
    @(negedge clk);
    check("resp_valid_one_cycle", resp_valid, 0);
    check("ready_after_done", cmd_ready, 1);
    check("idle_not_busy", busy, 0);
    check("r1_held", resp_r1, er1);
    check("timeout_held", resp_timeout, eto);
    check("single_pulse", rv_count - rv0, 1);
    check("no_write_when_full", viol_w - vw0, 0);
    check("no_read_when_empty", viol_r - vr0, 0);
    stall_at = -1;
  endtask

  initial begin
    logic [7:0] golden0[6];
    logic [7:0] golden8[6];
    logic [5:0] ridx;
    logic [31:0] rarg;
    int rv0, nb, st;
    golden0 = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    golden8 = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};

    rst = 1'b1; cmd_valid = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    check("idle_busy_low", busy, 0);

    // CMD0 with 0xFF then 0x01
    script.delete(); script.push_back(8'hFF); script.push_back(8'h01);
    run_cmd(6'd0, 32'h0000_0000, -1, 1'b0);
    for (int k = 0; k < 6; k++)
      if (wbase + k < txall.size()) check($sformatf("cmd0_golden%0d", k), txall[wbase + k], golden0[k]);

    // CMD8 with immediate R1
    script.delete(); script.push_back(8'h01);
    run_cmd(6'd8, 32'h0000_01AA, -1, 1'b0);
    for (int k = 0; k < 6; k++)
      if (wbase + k < txall.size()) check($sformatf("cmd8_golden%0d", k), txall[wbase + k], golden8[k]);

    // Card never answers
    script.delete();
    run_cmd(6'd17, 32'h1234_5678, -1, 1'b0);

    // TX FIFO full for 20 cycles mid-frame
    script.delete(); script.push_back(8'hC3); script.push_back(8'h00);
    run_cmd(6'd55, 32'hDEAD_BEEF, 2, 1'b0);

    // cmd_valid while busy is ignored
    script.delete(); script.push_back(8'h05);
    run_cmd(6'd41, 32'h4000_0000, -1, 1'b1);

    // Reset in the middle of XFER
    script.delete(); script.push_back(8'h00);
    rv0 = rv_count;
    issue_cmd(6'd9, 32'hA5A5_5A5A, -1);
    @(negedge clk);
    cmd_index = 6'd3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_mid_xfer", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", cmd_ready, 1);
    repeat (20) @(negedge clk);
    check("no_resp_after_abort", rv_count - rv0, 0);
    check("idle_after_abort", busy, 0);
    script.delete(); script.push_back(8'hFE); script.push_back(8'h01);
    run_cmd(6'd0, 32'h0000_0000, -1, 1'b0);

    // Randomized commands
    for (int n = 0; n < 10; n++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      script.delete();
      nb = $urandom_range(0, 10);
      for (int k = 0; k < nb; k++) script.push_back(8'($urandom) | 8'h80);
      if ($urandom_range(0, 3) != 0) script.push_back(8'($urandom) & 8'h7F);
      st = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 9)) : -1;
      run_cmd(ridx, rarg, st, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
